// File: rtl/demux_ctrl_pkg.sv
// Shared constants and types for the 1-to-4 demux dispatcher.
package demux_ctrl_pkg;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_FIX = 1'b1;

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Cyclic first-set search over the channel enable mask, starting at ptr.
module rr_pick
   import demux_ctrl_pkg::*;
(
   input  logic [SEL_W-1:0] ptr,
   input  logic [N_CH-1:0]  en,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   // Scan from the farthest offset back to ptr so the nearest enabled channel wins.
   always_comb begin
      pick = ptr;
      any  = 1'b0;
      idx  = '0;
      for (int unsigned k = N_CH; k > 0; k--) begin
         idx = ptr + SEL_W'(k - 1);
         if (en[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Dispatcher steering a valid/ready word stream to one of four channels,
// round-robin with configurable bursts or pinned to a fixed channel.
module demux_rr_dispatcher
   import demux_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned BURST  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              cfg_mode,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [N_CH-1:0]   cfg_en,
   output logic [N_CH-1:0]   out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic [N_CH-1:0]   out_ready,
   output logic [SEL_W-1:0]  sel,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(BURST + 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d, ptr_post;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d, bcnt_post;
   logic              mode_q, mode_d;
   logic [SEL_W-1:0]  pick;
   logic              any, deliver, eligible, ready_int, accept;

   rr_pick u_pick (
      .ptr  (ptr_post),
      .en   (cfg_en),
      .pick (pick),
      .any  (any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         bcnt_q  <= '0;
         mode_q  <= MODE_RR;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         bcnt_q  <= bcnt_d;
         mode_q  <= mode_d;
      end
   end

   // Delivery bookkeeping is resolved first so a same-cycle accept picks from the updated ptr/bcnt.
   always_comb begin
      deliver   = (state_q == SEND) & out_ready[sel_q];
      ptr_post  = ptr_q;
      bcnt_post = bcnt_q;
      if (deliver && (mode_q == MODE_RR)) begin
         if (bcnt_q + 1'b1 == CNT_W'(BURST)) begin
            ptr_post  = sel_q + 1'b1;
            bcnt_post = '0;
         end else begin
            ptr_post  = sel_q;
            bcnt_post = bcnt_q + 1'b1;
         end
      end
      eligible  = (cfg_mode == MODE_FIX) | any;
      ready_int = ((state_q == IDLE) | deliver) & eligible;
      accept    = in_valid & ready_int;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      ptr_d   = ptr_post;
      bcnt_d  = bcnt_post;
      if (accept) begin
         state_d = SEND;
         data_d  = in_data;
         mode_d  = cfg_mode;
         if (cfg_mode == MODE_FIX) begin
            sel_d = cfg_sel;
         end else begin
            sel_d = pick;
            // Skipping past ptr starts a fresh burst on the chosen channel.
            if (pick != ptr_post) bcnt_d = '0;
         end
      end else if (deliver) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      in_ready  = ready_int;
      out_valid = (state_q == SEND) ? (N_CH'(1) << sel_q) : '0;
      out_data  = data_q;
      sel       = sel_q;
      busy      = (state_q == SEND);
   end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: two instances (BURST=2 and BURST=1) against a behavioural model.
module tb_demux_rr_dispatcher;

   logic       clk = 1'b0;
   logic       rst_s       [2];
   logic       in_valid_s  [2];
   logic [7:0] in_data_s   [2];
   logic       in_ready_s  [2];
   logic       cfg_mode_s  [2];
   logic [1:0] cfg_sel_s   [2];
   logic [3:0] cfg_en_s    [2];
   logic [3:0] out_valid_s [2];
   logic [7:0] out_data_s  [2];
   logic [3:0] out_ready_s [2];
   logic [1:0] sel_s       [2];
   logic       busy_s      [2];

   int tot = 0;
   int bad = 0;

   bit         m_full [2];
   bit         m_fix  [2];
   logic [7:0] m_data [2];
   int         m_sel  [2];
   int         m_ptr  [2];
   int         m_cnt  [2];

   int         log_d = -1;
   int         obs_ch[$];
   logic [7:0] obs_data[$];

   always #5 clk = ~clk;

   demux_rr_dispatcher #(.DATA_W(8), .BURST(2)) u_b2 (
      .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
      .in_ready(in_ready_s[0]), .cfg_mode(cfg_mode_s[0]), .cfg_sel(cfg_sel_s[0]),
      .cfg_en(cfg_en_s[0]), .out_valid(out_valid_s[0]), .out_data(out_data_s[0]),
      .out_ready(out_ready_s[0]), .sel(sel_s[0]), .busy(busy_s[0])
   );

   demux_rr_dispatcher #(.DATA_W(8), .BURST(1)) u_b1 (
      .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
      .in_ready(in_ready_s[1]), .cfg_mode(cfg_mode_s[1]), .cfg_sel(cfg_sel_s[1]),
      .cfg_en(cfg_en_s[1]), .out_valid(out_valid_s[1]), .out_data(out_data_s[1]),
      .out_ready(out_ready_s[1]), .sel(sel_s[1]), .busy(busy_s[1])
   );

   function automatic int burst_of(int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int first_en(int p, logic [3:0] en);
      int r;
      r = -1;
      for (int k = 3; k >= 0; k--) if (en[(p + k) % 4]) r = (p + k) % 4;
      return r;
   endfunction

   function automatic bit exp_ready(int d);
      bit dlv;
      dlv = m_full[d] && out_ready_s[d][m_sel[d]];
      return (!m_full[d] || dlv) && (cfg_mode_s[d] || (cfg_en_s[d] != 4'b0));
   endfunction

   function automatic logic [3:0] exp_ov(int d);
      return m_full[d] ? 4'(1 << m_sel[d]) : 4'b0;
   endfunction

   task automatic model_reset(input int d);
      m_full[d] = 0; m_fix[d] = 0; m_data[d] = 8'h00;
      m_sel[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
   endtask

   task automatic model_step(input int d);
      bit dlv, acc;
      int p, c, dst;
      if (rst_s[d]) begin
         model_reset(d);
         return;
      end
      dlv = m_full[d] && out_ready_s[d][m_sel[d]];
      acc = in_valid_s[d] && exp_ready(d);
      p = m_ptr[d];
      c = m_cnt[d];
      if (dlv && !m_fix[d]) begin
         if (c + 1 == burst_of(d)) begin p = (m_sel[d] + 1) % 4; c = 0; end
         else begin p = m_sel[d]; c = c + 1; end
      end
      if (acc) begin
         m_data[d] = in_data_s[d];
         m_fix[d]  = cfg_mode_s[d];
         m_full[d] = 1;
         if (cfg_mode_s[d]) m_sel[d] = int'(cfg_sel_s[d]);
         else begin
            dst = first_en(p, cfg_en_s[d]);
            if (dst != p) c = 0;
            m_sel[d] = dst;
         end
      end else if (dlv) begin
         m_full[d] = 0;
      end
      m_ptr[d] = p;
      m_cnt[d] = c;
   endtask

   // Record deliveries about to happen at the coming edge, advance the model, move to next negedge.
   task automatic tick();
      for (int d = 0; d < 2; d++) begin
         if (!rst_s[d] && d == log_d)
            for (int c = 0; c < 4; c++)
               if (out_valid_s[d][c] && out_ready_s[d][c]) begin
                  obs_ch.push_back(c);
                  obs_data.push_back(out_data_s[d]);
               end
         model_step(d);
      end
      @(negedge clk);
   endtask

   task automatic start_log(input int d);
      log_d = d;
      obs_ch.delete();
      obs_data.delete();
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         tot++; if (out_valid_s[d] !== 4'b0000) begin bad++; $display("FAIL reset_out_valid d=%0d got=%b exp=0000", d, out_valid_s[d]); end
         tot++; if (sel_s[d] !== 2'b00 || busy_s[d] !== 1'b0) begin bad++; $display("FAIL reset_sel_busy d=%0d got=%b/%b exp=00/0", d, sel_s[d], busy_s[d]); end
         tot++; if (out_data_s[d] !== 8'h00) begin bad++; $display("FAIL reset_out_data d=%0d got=%h exp=00", d, out_data_s[d]); end
         tot++; if (in_ready_s[d] !== 1'b0) begin bad++; $display("FAIL reset_in_ready_noen d=%0d got=%b exp=0", d, in_ready_s[d]); end
         cfg_en_s[d] = 4'hF;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         tot++; if (in_ready_s[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready_en d=%0d got=%b exp=1", d, in_ready_s[d]); end
         cfg_en_s[d] = 4'h0;
      end
      tick();
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
   endtask

   task automatic test_rr_burst();
      start_log(0);
      cfg_mode_s[0] = 1'b0; cfg_en_s[0] = 4'hF; out_ready_s[0] = 4'hF;
      for (int i = 0; i < 9; i++) begin
         in_valid_s[0] = (i < 8);
         in_data_s[0]  = 8'h10 + 8'(i);
         #1;
         tot++; if (in_ready_s[0] !== 1'b1) begin bad++; $display("FAIL rr_burst_in_ready cyc=%0d got=%b exp=1", i, in_ready_s[0]); end
         tot++; if (out_valid_s[0] !== exp_ov(0)) begin bad++; $display("FAIL rr_burst_out_valid cyc=%0d got=%b exp=%b", i, out_valid_s[0], exp_ov(0)); end
         tick();
      end
      in_valid_s[0] = 1'b0;
      tot++; if (obs_ch.size() != 8) begin bad++; $display("FAIL rr_burst_count got=%0d exp=8", obs_ch.size()); end
      for (int i = 0; i < 8 && i < obs_ch.size(); i++) begin
         tot++;
         if (obs_ch[i] != i / 2 || obs_data[i] !== 8'h10 + 8'(i)) begin
            bad++; $display("FAIL rr_burst_delivery i=%0d got=ch%0d/%h exp=ch%0d/%h", i, obs_ch[i], obs_data[i], i / 2, 8'h10 + 8'(i));
         end
      end
   endtask

   task automatic test_rr_sparse();
      int exp_ch[4] = '{1, 3, 1, 3};
      start_log(1);
      cfg_mode_s[1] = 1'b0; cfg_en_s[1] = 4'b1010; out_ready_s[1] = 4'hF;
      for (int i = 0; i < 5; i++) begin
         in_valid_s[1] = (i < 4);
         in_data_s[1]  = 8'hA0 + 8'(i);
         #1;
         tot++; if (out_valid_s[1] !== exp_ov(1)) begin bad++; $display("FAIL sparse_out_valid cyc=%0d got=%b exp=%b", i, out_valid_s[1], exp_ov(1)); end
         tick();
      end
      tot++; if (obs_ch.size() != 4) begin bad++; $display("FAIL sparse_count got=%0d exp=4", obs_ch.size()); end
      for (int i = 0; i < 4 && i < obs_ch.size(); i++) begin
         tot++;
         if (obs_ch[i] != exp_ch[i] || obs_data[i] !== 8'hA0 + 8'(i)) begin
            bad++; $display("FAIL sparse_delivery i=%0d got=ch%0d/%h exp=ch%0d/%h", i, obs_ch[i], obs_data[i], exp_ch[i], 8'hA0 + 8'(i));
         end
      end
      cfg_en_s[1] = 4'b0000; in_valid_s[1] = 1'b1; in_data_s[1] = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         #1;
         tot++; if (in_ready_s[1] !== 1'b0 || busy_s[1] !== 1'b0) begin bad++; $display("FAIL sparse_noen cyc=%0d got=ready%b/busy%b exp=0/0", i, in_ready_s[1], busy_s[1]); end
         tick();
      end
      in_valid_s[1] = 1'b0;
   endtask

   task automatic test_backpressure();
      start_log(0);
      cfg_mode_s[0] = 1'b0; cfg_en_s[0] = 4'hF; out_ready_s[0] = 4'b1110;
      in_valid_s[0] = 1'b1; in_data_s[0] = 8'h55;
      #1;
      tot++; if (in_ready_s[0] !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b exp=1", in_ready_s[0]); end
      tick();
      in_data_s[0] = 8'h66;
      for (int i = 0; i < 3; i++) begin
         #1;
         tot++;
         if (out_valid_s[0] !== 4'b0001 || out_data_s[0] !== 8'h55 || in_ready_s[0] !== 1'b0) begin
            bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=0001/55/0", i, out_valid_s[0], out_data_s[0], in_ready_s[0]);
         end
         tick();
      end
      out_ready_s[0] = 4'hF;
      #1;
      tot++; if (in_ready_s[0] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready_s[0]); end
      tick();
      in_valid_s[0] = 1'b0;
      #1;
      tot++; if (out_valid_s[0] !== 4'b0001 || out_data_s[0] !== 8'h66) begin bad++; $display("FAIL bp_next_word got=%b/%h exp=0001/66", out_valid_s[0], out_data_s[0]); end
      tick();
      tot++;
      if (obs_ch.size() != 2 || obs_data[0] !== 8'h55 || obs_data[1] !== 8'h66 || obs_ch[0] != 0 || obs_ch[1] != 0) begin
         bad++; $display("FAIL bp_deliveries got=%0d entries exp=2 (ch0/55, ch0/66)", obs_ch.size());
      end
   endtask

   task automatic test_fixed();
      start_log(0);
      cfg_mode_s[0] = 1'b1; cfg_sel_s[0] = 2'd2; cfg_en_s[0] = 4'b0000; out_ready_s[0] = 4'hF;
      for (int i = 0; i < 4; i++) begin
         in_valid_s[0] = (i < 3);
         in_data_s[0]  = 8'h01 + 8'(i);
         #1;
         tot++; if (in_ready_s[0] !== 1'b1) begin bad++; $display("FAIL fixed_in_ready cyc=%0d got=%b exp=1", i, in_ready_s[0]); end
         tick();
      end
      tot++; if (obs_ch.size() != 3) begin bad++; $display("FAIL fixed_count got=%0d exp=3", obs_ch.size()); end
      for (int i = 0; i < obs_ch.size(); i++) begin
         tot++; if (obs_ch[i] != 2) begin bad++; $display("FAIL fixed_channel i=%0d got=%0d exp=2", i, obs_ch[i]); end
      end
      start_log(0);
      cfg_mode_s[0] = 1'b0; cfg_en_s[0] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         in_valid_s[0] = (i < 2);
         in_data_s[0]  = 8'h21 + 8'(i);
         #1;
         tick();
      end
      tot++;
      if (obs_ch.size() != 2 || obs_ch[0] != 1 || obs_ch[1] != 1) begin
         bad++; $display("FAIL fixed_rr_resume got=%0d entries first_ch=%0d exp=2 entries on ch1", obs_ch.size(), (obs_ch.size() > 0) ? obs_ch[0] : -1);
      end
   endtask

   task automatic test_cfg_change();
      start_log(0);
      cfg_mode_s[0] = 1'b0; cfg_en_s[0] = 4'b0010; out_ready_s[0] = 4'b1101;
      in_valid_s[0] = 1'b1; in_data_s[0] = 8'h77;
      #1;
      tick();
      in_valid_s[0] = 1'b0; cfg_mode_s[0] = 1'b1; cfg_sel_s[0] = 2'd3; cfg_en_s[0] = 4'hF;
      for (int i = 0; i < 2; i++) begin
         #1;
         tot++;
         if (out_valid_s[0] !== 4'b0010 || sel_s[0] !== 2'd1 || out_data_s[0] !== 8'h77) begin
            bad++; $display("FAIL cfg_change_hold cyc=%0d got=%b/%0d/%h exp=0010/1/77", i, out_valid_s[0], sel_s[0], out_data_s[0]);
         end
         tick();
      end
      out_ready_s[0] = 4'hF;
      #1;
      tick();
      tot++; if (busy_s[0] !== 1'b0) begin bad++; $display("FAIL cfg_change_drained got=%b exp=0", busy_s[0]); end
      tot++;
      if (obs_ch.size() != 1 || obs_ch[0] != 1 || obs_data[0] !== 8'h77) begin
         bad++; $display("FAIL cfg_change_delivery got=%0d entries exp=1 on ch1/77", obs_ch.size());
      end
      cfg_mode_s[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_log(0);
      cfg_mode_s[0] = 1'b0; cfg_en_s[0] = 4'hF; out_ready_s[0] = 4'b0000;
      in_valid_s[0] = 1'b1; in_data_s[0] = 8'h88;
      #1;
      tick();
      in_valid_s[0] = 1'b0;
      #1;
      rst_s[0] = 1'b1;
      #1;
      tot++;
      if (out_valid_s[0] !== 4'b0000 || sel_s[0] !== 2'b00 || busy_s[0] !== 1'b0) begin
         bad++; $display("FAIL rst_mid_async got=%b/%b/%b exp=0000/00/0", out_valid_s[0], sel_s[0], busy_s[0]);
      end
      model_reset(0);
      tick();
      rst_s[0] = 1'b0;
      out_ready_s[0] = 4'hF;
      in_valid_s[0] = 1'b1; in_data_s[0] = 8'h99;
      #1;
      tot++; if (in_ready_s[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready_s[0]); end
      tick();
      in_valid_s[0] = 1'b0;
      #1;
      tot++;
      if (out_valid_s[0] !== 4'b0001 || sel_s[0] !== 2'd0 || out_data_s[0] !== 8'h99) begin
         bad++; $display("FAIL rst_mid_next got=%b/%0d/%h exp=0001/0/99", out_valid_s[0], sel_s[0], out_data_s[0]);
      end
      tick();
      tot++;
      if (obs_ch.size() != 1 || obs_data[0] !== 8'h99) begin
         bad++; $display("FAIL rst_mid_deliveries got=%0d entries exp=1 (only 99)", obs_ch.size());
      end
   endtask

   task automatic test_random();
      log_d = -1;
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            in_valid_s[d]  = ($urandom_range(0, 3) != 0);
            in_data_s[d]   = 8'($urandom);
            cfg_mode_s[d]  = ($urandom_range(0, 4) == 0);
            cfg_sel_s[d]   = 2'($urandom);
            cfg_en_s[d]    = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            out_ready_s[d] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            tot++;
            if (in_ready_s[d] !== exp_ready(d) || out_valid_s[d] !== exp_ov(d) || busy_s[d] !== m_full[d]) begin
               bad++; $display("FAIL rand_ctrl cyc=%0d d=%0d got=rdy%b/ov%b/busy%b exp=rdy%b/ov%b/busy%b", i, d,
                               in_ready_s[d], out_valid_s[d], busy_s[d], exp_ready(d), exp_ov(d), m_full[d]);
            end
            tot++;
            if (out_data_s[d] !== m_data[d] || sel_s[d] !== 2'(m_sel[d])) begin
               bad++; $display("FAIL rand_data cyc=%0d d=%0d got=%h/%0d exp=%h/%0d", i, d, out_data_s[d], sel_s[d], m_data[d], m_sel[d]);
            end
         end
         tick();
      end
      for (int d = 0; d < 2; d++) in_valid_s[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; in_valid_s[d] = 1'b0; in_data_s[d] = 8'h00;
         cfg_mode_s[d] = 1'b0; cfg_sel_s[d] = 2'd0; cfg_en_s[d] = 4'h0; out_ready_s[d] = 4'h0;
         model_reset(d);
      end
      @(negedge clk);
      #1;
      test_reset();
      test_rr_burst();
      test_rr_sparse();
      test_backpressure();
      test_fixed();
      test_cfg_change();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

Sequencing controller for the 1-to-4 demultiplexer: accepts a word stream over a valid/ready handshake and steers each word to one of four downstream channels, either round-robin with a configurable burst length or pinned to a fixed channel. It owns the demux select, holds the in-flight word and presents it to exactly one channel. It sits between a single producer and four consumers.

## Interface
- DATA_W, 8, width of a data word
- BURST, 2, words sent to one channel before round-robin rotation (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- in_valid  in  1  producer word valid
- in_data  in  DATA_W  producer word
- in_ready  out  1  dispatcher accepts word this cycle
- cfg_mode  in  1  0 = round-robin, 1 = fixed channel
- cfg_sel  in  2  channel used in fixed mode
- cfg_en  in  4  per-channel enable mask, round-robin mode only
- out_valid  out  4  one-hot valid to channel k, all-zero when empty
- out_data  out  DATA_W  held word, shared by all channels
- out_ready  in  4  per-channel consumer ready
- sel  out  2  current destination, drives demux select
- busy  out  1  word held (state SEND)

## Operation
- States: IDLE (empty), SEND (word held, out_valid[sel]=1).
- Accept = in_valid & in_ready. Deliver = SEND & out_ready[sel].
- in_ready = (IDLE | Deliver) & eligible. In round-robin, eligible = |cfg_en. Fixed mode is always eligible.
- On accept: latch in_data into out_data and latch the destination into sel. Go to or stay in SEND.
- Destination, round-robin: the first channel with cfg_en=1 scanning cyclically from ptr (ptr, ptr+1, … mod 4).
- Destination, fixed mode: cfg_sel. cfg_en is ignored.
- cfg_* is sampled only at accept. Changing it while in SEND does not affect the held word.
- On Deliver in round-robin mode, where the word's recorded mode is rr:
  - bcnt+1 == BURST → ptr = sel+1 mod 4, bcnt = 0.
  - otherwise → ptr = sel, bcnt = bcnt+1.
- Fixed-mode deliveries leave ptr and bcnt unchanged.
- Deliver without Accept → IDLE. Deliver with Accept → stay in SEND with the new word.
- Simultaneous Deliver and Accept: the new destination is computed from the post-delivery ptr/bcnt.
- If the destination skips past ptr to an enabled channel, bcnt restarts at 0 for that channel.
- Arithmetic: ptr and sel wrap mod 4 (2-bit). bcnt is clog2(BURST+1) bits and never exceeds BURST-1.

## Timing
- Reset values: state IDLE, out_valid=0000, out_data=0, sel=00, busy=0, ptr=0, bcnt=0. in_ready follows its combinational rule (1 if eligible).
- Reset mid-operation: the held word is discarded, with no delivery. Outputs go to reset values asynchronously.
- Latency: accept at edge N → out_valid[sel]=1 from edge N through the delivering edge.
- Throughput: 1 word/cycle when the destination consumer is continuously ready.
- out_valid, out_data and sel are registered, with no combinational path from in_* to them.
- in_ready depends combinationally on out_ready[sel], cfg_mode and cfg_en.
- A held word is never dropped or retargeted. out_data and sel are stable while out_valid is high and not delivered.

## Structure
- Package demux_ctrl_pkg:
  - N_CH=4, SEL_W=2
  - state enum {IDLE, SEND}
  - mode constants MODE_RR=0, MODE_FIX=1
- Sub-module rr_pick: combinational.
  - Inputs: ptr[1:0], en[3:0].
  - Outputs: pick[1:0], any.
  - Cyclic first-set search from ptr.
- Top: state/data/sel registers, ptr/bcnt update, handshake logic.

## Test plan
- Round-robin, BURST=2, cfg_en=1111, all out_ready=1, words 0x10..0x17 back-to-back → channels 0,0,1,1,2,2,3,3, one per cycle, in_ready constantly 1.
- cfg_en=1010, BURST=1, words A0..A3 → channels 1,3,1,3. Then cfg_en=0000 → in_ready=0 and state stays IDLE.
- Backpressure: out_ready[0]=0 for 3 cycles with word 0x55 held → out_valid=0001 and out_data=0x55 stable, in_ready=0. Releasing ready → single delivery, next word accepted the same cycle.
- Fixed mode, cfg_sel=2, cfg_en=0000, words 0x01..0x03 → all on channel 2. Return to rr → resumes at ptr/bcnt unchanged from before fixed mode.
- Config change while in SEND (word to channel 1, then cfg_mode=1, cfg_sel=3 before delivery) → word still delivered on channel 1.
- Assert rst mid-SEND → out_valid=0000, sel=00, busy=0 immediately. After release, the next word goes to channel 0.
